// File: rtl/fetch_pkg.sv
// Shared fetch front-end types: FSM states, IF/ID bundle, defaults.
// Imported by the fetch redirect unit and its hold buffer.
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP_DEF  = 32'd4;

   typedef enum logic [1:0] {
      S_RESET,
      S_REQ,
      S_DRAIN,
      S_HOLD
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instr+pc buffer that catches a fetch response
// arriving while the IF/ID register is stalled.
module fetch_hold_buf
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_i,
   input  logic [XLEN-1:0] wr_instr_i,
   input  logic [XLEN-1:0] wr_pc_i,
   input  logic            clr_i,
   output logic [XLEN-1:0] rd_instr_o,
   output logic [XLEN-1:0] rd_pc_o,
   output logic            full_o
);

   logic            full_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q  <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else if (clr_i) begin
         full_q  <= 1'b0;
      end else if (wr_i) begin
         full_q  <= 1'b1;
         instr_q <= wr_instr_i;
         pc_q    <= wr_pc_i;
      end
   end

   assign rd_instr_o = instr_q;
   assign rd_pc_o    = pc_q;
   assign full_o     = full_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: PC, imem req/ack, branch redirect with
// drain of stale responses, and stall hold into IF/ID.
module fetch_redirect_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br,
   input  logic [XLEN-1:0] br_pc,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_ack,
   output logic [XLEN-1:0] if_id_instr,
   output logic [XLEN-1:0] if_id_pc,
   output logic            if_id_valid
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] redir_q, redir_d;
   if_id_t          ifid_q, ifid_d;

   logic            buf_wr, buf_clr, buf_full;
   logic [XLEN-1:0] buf_instr, buf_pc;
   logic            load;
   if_id_t          load_v;

   fetch_hold_buf u_hold (
      .clk        (clk),
      .rst        (rst),
      .wr_i       (buf_wr),
      .wr_instr_i (imem_rdata),
      .wr_pc_i    (pc_q),
      .clr_i      (buf_clr),
      .rd_instr_o (buf_instr),
      .rd_pc_o    (buf_pc),
      .full_o     (buf_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RESET;
         pc_q    <= RESET_PC;
         redir_q <= '0;
         ifid_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         redir_q <= redir_d;
         ifid_q  <= ifid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      redir_d = redir_q;
      buf_wr  = 1'b0;
      buf_clr = 1'b0;
      load    = 1'b0;
      load_v  = '0;
      unique case (state_q)
         S_RESET: state_d = S_REQ;
         S_REQ: begin
            if (imem_ack) begin
               if (br) begin
                  pc_d = br_pc;
               end else begin
                  pc_d = pc_q + PC_STEP;
                  if (stall) begin
                     buf_wr  = 1'b1;
                     state_d = S_HOLD;
                  end else begin
                     load         = 1'b1;
                     load_v.instr = imem_rdata;
                     load_v.pc    = pc_q;
                     load_v.valid = 1'b1;
                  end
               end
            end else if (br) begin
               // keep pc_q so the outstanding address stays stable
               redir_d = br_pc;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (br) redir_d = br_pc;
            if (imem_ack) begin
               pc_d    = br ? br_pc : redir_q;
               state_d = S_REQ;
            end
         end
         S_HOLD: begin
            if (br) begin
               buf_clr = 1'b1;
               pc_d    = br_pc;
               state_d = S_REQ;
            end else if (!stall) begin
               buf_clr      = 1'b1;
               state_d      = S_REQ;
               load         = buf_full;
               load_v.instr = buf_instr;
               load_v.pc    = buf_pc;
               load_v.valid = 1'b1;
            end
         end
         default: state_d = S_RESET;
      endcase

      if (br) begin
         ifid_d = '0;
      end else if (stall) begin
         ifid_d = ifid_q;
      end else if (load) begin
         ifid_d = load_v;
      end else begin
         ifid_d       = ifid_q;
         ifid_d.valid = 1'b0;
      end
   end

   assign imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
   assign imem_addr   = pc_q;
   assign if_id_instr = ifid_q.instr;
   assign if_id_pc    = ifid_q.pc;
   assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: latency-programmable memory,
// transaction-level reference model and directed scenarios.
module tb_fetch_redirect_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br = 1'b0;
   logic [31:0] br_pc = '0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_valid;

   int   checks = 0;
   int   errors = 0;
   int   lat = 0;
   int   wait_cnt = 0;
   logic ack_force = 1'b0;

   fetch_redirect_unit dut (
      .clk         (clk),
      .rst         (rst),
      .br          (br),
      .br_pc       (br_pc),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ack    (imem_ack),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc),
      .if_id_valid (if_id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h1300_0000;
   endfunction

   // memory: ack once the request has waited lat cycles
   always @(posedge clk) begin
      if (!imem_req || imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end
   assign imem_ack = ack_force ||
                     (imem_req && (wait_cnt >= lat));
   assign imem_rdata = ack_force ? 32'hBAD0_BAD0
                                 : mem_data(imem_addr);

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   // reference model in terms of fetch transactions
   logic        m_init = 1'b0;
   logic        m_run = 1'b0;
   logic [31:0] m_addr = '0;
   logic        m_stale = 1'b0;
   logic [31:0] m_tgt = '0;
   logic        m_bv = 1'b0;
   logic [31:0] m_bpc = '0;
   logic [31:0] m_binstr = '0;
   logic        m_ifv = 1'b0;
   logic [31:0] m_ifpc = '0;
   logic [31:0] m_ifinstr = '0;

   always @(posedge clk) begin
      logic        ld;
      logic [31:0] lpc, linstr;
      ld = 1'b0;
      lpc = '0;
      linstr = '0;
      m_init = 1'b1;
      if (rst) begin
         m_run = 1'b0;
         m_addr = 32'h0;
         m_stale = 1'b0;
         m_bv = 1'b0;
         m_ifv = 1'b0;
         m_ifpc = '0;
         m_ifinstr = '0;
      end else begin
         if (!m_run) begin
            m_run = 1'b1;
         end else if (m_bv) begin
            if (br) begin
               m_bv = 1'b0;
               m_addr = br_pc;
            end else if (!stall) begin
               ld = 1'b1;
               lpc = m_bpc;
               linstr = m_binstr;
               m_bv = 1'b0;
            end
         end else if (imem_ack) begin
            if (m_stale) begin
               m_stale = 1'b0;
               m_addr = br ? br_pc : m_tgt;
            end else if (br) begin
               m_addr = br_pc;
            end else if (stall) begin
               m_bv = 1'b1;
               m_bpc = m_addr;
               m_binstr = imem_rdata;
               m_addr = m_addr + 32'd4;
            end else begin
               ld = 1'b1;
               lpc = m_addr;
               linstr = imem_rdata;
               m_addr = m_addr + 32'd4;
            end
         end else if (br) begin
            m_stale = 1'b1;
            m_tgt = br_pc;
         end
         if (br) begin
            m_ifv = 1'b0;
            m_ifpc = '0;
            m_ifinstr = '0;
         end else if (!stall) begin
            if (ld) begin
               m_ifv = 1'b1;
               m_ifpc = lpc;
               m_ifinstr = linstr;
            end else begin
               m_ifv = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("req", {31'b0, imem_req},
             {31'b0, m_run && !m_bv});
         if (!m_bv) chk("addr", imem_addr, m_addr);
         chk("valid", {31'b0, if_id_valid}, {31'b0, m_ifv});
         if (m_ifv) begin
            chk("ifpc", if_id_pc, m_ifpc);
            chk("instr", if_id_instr, m_ifinstr);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      br = 1'b0;
      stall = 1'b0;
      lat = 0;
      ack_force = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_leave(input logic [31:0] a);
      for (int i = 0; i < 12; i++) begin
         if (imem_addr != a) break;
         @(negedge clk);
      end
   endtask

   initial begin
      // 1: streaming with zero-wait memory
      do_reset();
      @(negedge clk);
      chk("t1_addr0", imem_addr, 32'h0);
      chk("t1_v0", {31'b0, if_id_valid}, 32'h0);
      @(negedge clk);
      chk("t1_addr4", imem_addr, 32'h4);
      chk("t1_pc0", if_id_pc, 32'h0);
      chk("t1_ins0", if_id_instr, 32'h1300_0000);
      @(negedge clk);
      chk("t1_addr8", imem_addr, 32'h8);
      @(negedge clk);
      chk("t1_addrC", imem_addr, 32'hC);
      chk("t1_pc8", if_id_pc, 32'h8);

      // 2: taken redirect coincident with ack for 8
      do_reset();
      repeat (3) @(negedge clk);
      br = 1'b1;
      br_pc = 32'h100;
      @(negedge clk);
      br = 1'b0;
      chk("t2_flush", {31'b0, if_id_valid}, 32'h0);
      chk("t2_tgt", imem_addr, 32'h100);
      @(negedge clk);
      chk("t2_next", imem_addr, 32'h104);
      chk("t2_pc", if_id_pc, 32'h100);

      // 3: drain a slow fetch to 0x10
      do_reset();
      repeat (5) @(negedge clk);
      chk("t3_at10", imem_addr, 32'h10);
      lat = 3;
      @(negedge clk);
      br = 1'b1;
      br_pc = 32'h200;
      @(negedge clk);
      br = 1'b0;
      chk("t3_hold", imem_addr, 32'h10);
      wait_leave(32'h10);
      chk("t3_tgt", imem_addr, 32'h200);
      chk("t3_disc", {31'b0, if_id_valid}, 32'h0);

      // 3b: a second redirect during the drain wins
      do_reset();
      repeat (5) @(negedge clk);
      lat = 3;
      @(negedge clk);
      br = 1'b1;
      br_pc = 32'h200;
      @(negedge clk);
      br_pc = 32'h300;
      @(negedge clk);
      br = 1'b0;
      wait_leave(32'h10);
      chk("t3b_tgt", imem_addr, 32'h300);

      // 4: stall 4 cycles while streaming
      do_reset();
      repeat (3) @(negedge clk);
      stall = 1'b1;
      @(negedge clk);
      chk("t4_req", {31'b0, imem_req}, 32'h0);
      chk("t4_pc", if_id_pc, 32'h4);
      repeat (3) @(negedge clk);
      stall = 1'b0;
      chk("t4_held", if_id_pc, 32'h4);
      @(negedge clk);
      chk("t4_buf", if_id_pc, 32'h8);
      chk("t4_res", imem_addr, 32'hC);
      @(negedge clk);
      chk("t4_nxt", if_id_pc, 32'hC);

      // 5: br and stall together while holding
      do_reset();
      repeat (3) @(negedge clk);
      stall = 1'b1;
      @(negedge clk);
      br = 1'b1;
      br_pc = 32'h40;
      @(negedge clk);
      br = 1'b0;
      stall = 1'b0;
      chk("t5_flush", {31'b0, if_id_valid}, 32'h0);
      chk("t5_tgt", imem_addr, 32'h40);
      @(negedge clk);
      chk("t5_pc", if_id_pc, 32'h40);

      // 6: reset mid-drain, stale ack right after
      do_reset();
      @(negedge clk);
      lat = 5;
      br = 1'b1;
      br_pc = 32'h80;
      @(negedge clk);
      br = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("t6_req", {31'b0, imem_req}, 32'h0);
      chk("t6_ins", if_id_instr, 32'h0);
      chk("t6_pc", if_id_pc, 32'h0);
      chk("t6_addr", imem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      ack_force = 1'b1;
      lat = 0;
      @(negedge clk);
      ack_force = 1'b0;
      chk("t6_first", imem_addr, 32'h0);
      chk("t6_noload", {31'b0, if_id_valid}, 32'h0);
      @(negedge clk);
      chk("t6_ins0", if_id_instr, 32'h1300_0000);

      // 7: PC wrap
      do_reset();
      @(negedge clk);
      br = 1'b1;
      br_pc = 32'hFFFF_FFF8;
      @(negedge clk);
      br = 1'b0;
      repeat (2) @(negedge clk);
      chk("t7_wrap", imem_addr, 32'h0);
      chk("t7_pc", if_id_pc, 32'hFFFF_FFFC);

      // 8: mixed pattern against the model
      do_reset();
      for (int i = 0; i < 80; i++) begin
         lat = (i % 9 < 4) ? 0 : 1;
         stall = (i % 7 == 3) || (i % 13 == 4);
         br = (i % 11 == 5);
         br_pc = 32'h1000 + i * 16;
         @(negedge clk);
      end
      br = 1'b0;
      stall = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
